// File: rtl/sigmoid_arb_pkg.sv
// Shared types and constants for the sigmoid datapath arbiter.
package sigmoid_arb_pkg;

  localparam int FLOAT_W = 32;
  localparam logic [FLOAT_W-1:0] FLOAT_HALF = 32'h3F00_0000;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } arb_state_e;

endpackage

// File: rtl/sigmoid_rr_arbiter.sv
// Grant selection for the sigmoid arbiter. SIGMOID_ARB_RR_EN selects round-robin
// with a last-grant pointer; otherwise fixed priority (lowest index wins).
module sigmoid_rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_valid,
  input  logic             accept,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_idx
);

`ifdef SIGMOID_ARB_RR_EN
  logic [ID_W-1:0] ptr_q, ptr_d;
  int              cand;

  // Walk offsets from farthest to nearest so the requester right after the pointer wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = (int'(ptr_q) + k) % N_REQ;
      if (req_valid[cand[ID_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = grant_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= ID_W'(N_REQ - 1);
    else       ptr_q <= ptr_d;
  end
`else
  logic unused_ok;
  assign unused_ok = ^{clk, reset, accept};

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[k[ID_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = k[ID_W-1:0];
      end
    end
  end
`endif

endmodule

// File: rtl/sigmoid_arbiter.sv
// Shares one combinational sigmoid datapath among N_REQ requesters, holding the
// operand for SETTLE_CYCLES before capturing the result. Policy: SIGMOID_ARB_RR_EN.
module sigmoid_arbiter
  import sigmoid_arb_pkg::*;
#(
  parameter  int N_REQ         = 4,
  parameter  int SETTLE_CYCLES = 1,
  localparam int ID_W          = $clog2(N_REQ),
  localparam int CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req_valid,
  input  logic [N_REQ-1:0][FLOAT_W-1:0]   req_x,
  output logic [N_REQ-1:0]                req_ready,
  output logic [FLOAT_W-1:0]              sig_x,
  input  logic [FLOAT_W-1:0]              sig_result,
  output logic                            rsp_valid,
  output logic [FLOAT_W-1:0]              rsp_result,
  output logic [ID_W-1:0]                 rsp_id,
  input  logic                            rsp_ready,
  output logic                            busy
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("sigmoid_arbiter: SETTLE_CYCLES must be at least 1");
  end

  arb_state_e         state_q, state_d;
  logic [FLOAT_W-1:0] x_q, x_d;
  logic [FLOAT_W-1:0] result_q, result_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               grant_valid;
  logic [ID_W-1:0]    grant_idx;
  logic               accept;

  assign accept = (state_q == IDLE) && grant_valid;

  sigmoid_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .accept      (accept),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    result_d = result_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          x_d     = req_x[grant_idx];
          id_d    = grant_idx;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          result_d = sig_result;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      result_q <= '0;
      id_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      result_q <= result_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
    end
  end

  // req_ready is combinational on reset so nothing is handed over while reset is held.
  always_comb begin
    req_ready = '0;
    if (accept && !reset) req_ready[grant_idx] = 1'b1;
  end

  assign sig_x      = x_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_result = result_q;
  assign rsp_id     = id_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Bench for sigmoid_arbiter: two instances (SETTLE_CYCLES=1 and 3), a cycle-level
// transaction model checked every cycle, and directed literal checks.
module tb_sigmoid_arbiter;
  import sigmoid_arb_pkg::*;

  localparam int N   = 4;
  localparam int S_A = 1;
  localparam int S_B = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]       a_req_valid, a_req_ready, b_req_valid, b_req_ready;
  logic [N-1:0][31:0] a_req_x, b_req_x;
  logic [31:0]        a_sig_x, a_sig_result, a_rsp_result;
  logic [31:0]        b_sig_x, b_sig_result, b_rsp_result;
  logic               a_rsp_valid, a_rsp_ready, a_busy;
  logic               b_rsp_valid, b_rsp_ready, b_busy;
  logic [1:0]         a_rsp_id, b_rsp_id;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Stand-in for the shared sigmoid datapath: exact at 0, distinctive elsewhere.
  function automatic logic [31:0] dp(input logic [31:0] x);
    return (x == 32'h0) ? FLOAT_HALF : {x[31:16] ^ 16'h3C3C, x[15:0]};
  endfunction

  assign a_sig_result = dp(a_sig_x);
  assign b_sig_result = dp(b_sig_x);

  sigmoid_arbiter #(.N_REQ(N), .SETTLE_CYCLES(S_A)) dut_a (
    .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_x(a_req_x),
    .req_ready(a_req_ready), .sig_x(a_sig_x), .sig_result(a_sig_result),
    .rsp_valid(a_rsp_valid), .rsp_result(a_rsp_result), .rsp_id(a_rsp_id),
    .rsp_ready(a_rsp_ready), .busy(a_busy)
  );

  sigmoid_arbiter #(.N_REQ(N), .SETTLE_CYCLES(S_B)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_x(b_req_x),
    .req_ready(b_req_ready), .sig_x(b_sig_x), .sig_result(b_sig_result),
    .rsp_valid(b_rsp_valid), .rsp_result(b_rsp_result), .rsp_id(b_rsp_id),
    .rsp_ready(b_rsp_ready), .busy(b_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner among valid requesters given the last granted index.
  function automatic int pick(input logic [N-1:0] v, input int last);
    int base;
`ifdef SIGMOID_ARB_RR_EN
    base = last;
`else
    base = N - 1;
`endif
    for (int o = 1; o <= N; o++) begin
      if (v[(base + o) % N]) return (base + o) % N;
    end
    return -1;
  endfunction

  // Model: a transaction is "in flight" for S cycles after acceptance, then
  // offered until handshaken.
  bit          m_active [2];
  int          m_age    [2];
  logic [31:0] m_x      [2];
  int          m_id     [2];
  logic [31:0] m_res    [2];
  int          m_last   [2];
  int          ms, mw;
  logic [N-1:0]       mv;
  logic [N-1:0][31:0] mxs;
  logic               mrr;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      ms  = (k == 0) ? S_A : S_B;
      mv  = (k == 0) ? a_req_valid : b_req_valid;
      mxs = (k == 0) ? a_req_x : b_req_x;
      mrr = (k == 0) ? a_rsp_ready : b_rsp_ready;
      if (reset) begin
        m_active[k] = 1'b0; m_age[k] = 0; m_x[k] = '0;
        m_id[k] = 0; m_res[k] = '0; m_last[k] = N - 1;
      end else if (!m_active[k]) begin
        mw = pick(mv, m_last[k]);
        if (mw >= 0) begin
          m_active[k] = 1'b1; m_age[k] = 0; m_x[k] = mxs[mw];
          m_id[k] = mw; m_last[k] = mw;
        end
      end else if (m_age[k] < ms) begin
        if (m_age[k] == ms - 1) m_res[k] = dp(m_x[k]);
        m_age[k]++;
      end else if (mrr) begin
        m_active[k] = 1'b0;
      end
    end
  end

  int           cs, cw;
  logic [N-1:0] cv, c_ready, exp_ready;
  logic         c_valid, c_busy, exp_valid;
  logic [31:0]  c_sig_x, c_res;
  logic [1:0]   c_id;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        cs      = (k == 0) ? S_A : S_B;
        cv      = (k == 0) ? a_req_valid : b_req_valid;
        c_ready = (k == 0) ? a_req_ready : b_req_ready;
        c_valid = (k == 0) ? a_rsp_valid : b_rsp_valid;
        c_busy  = (k == 0) ? a_busy : b_busy;
        c_sig_x = (k == 0) ? a_sig_x : b_sig_x;
        c_res   = (k == 0) ? a_rsp_result : b_rsp_result;
        c_id    = (k == 0) ? a_rsp_id : b_rsp_id;
        exp_ready = '0;
        if (!reset && !m_active[k]) begin
          cw = pick(cv, m_last[k]);
          if (cw >= 0) exp_ready[cw] = 1'b1;
        end
        chk($sformatf("model_req_ready%0d", k), 32'(c_ready), 32'(exp_ready));
        if (!reset) begin
          exp_valid = m_active[k] && (m_age[k] >= cs);
          chk($sformatf("model_sig_x%0d", k), c_sig_x, m_x[k]);
          chk($sformatf("model_busy%0d", k), 32'(c_busy), 32'(m_active[k]));
          chk($sformatf("model_rsp_valid%0d", k), 32'(c_valid), 32'(exp_valid));
          if (exp_valid) begin
            chk($sformatf("model_rsp_result%0d", k), c_res, m_res[k]);
            chk($sformatf("model_rsp_id%0d", k), 32'(c_id), 32'(m_id[k]));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge of the first cycle with rsp_valid, or after lim cycles.
  task automatic wait_rsp(input int k, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if ((k == 0) ? a_rsp_valid : b_rsp_valid) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic wait_idle(input int k, input int lim);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      step();
      @(negedge clk);
      ok = !((k == 0) ? a_busy : b_busy);
    end
    chk($sformatf("idle_timeout%0d", k), 32'(ok), 32'd1);
  endtask

  int          ids[$];
  int          accs[$];
  int          cyc;
  bit          ok;
  logic [31:0] held_res;
  logic [1:0]  held_id;
  int          exp_ids[5];

  initial begin
`ifdef SIGMOID_ARB_RR_EN
    exp_ids = '{0, 1, 2, 3, 0};
`else
    exp_ids = '{0, 0, 0, 0, 0};
`endif
    a_req_valid = 4'b1111; a_req_x = '0; a_rsp_ready = 1'b0;
    b_req_valid = 4'b1111; b_req_x = '0; b_rsp_ready = 1'b0;
    reset = 1'b1;
    step(); chk_en = 1'b1;
    step();
    @(negedge clk);
    chk("rst_req_ready_a", 32'(a_req_ready), 32'd0);
    chk("rst_req_ready_b", 32'(b_req_ready), 32'd0);
    step(); reset = 1'b0; a_req_valid = '0; b_req_valid = '0;
    @(negedge clk);
    chk("post_rst_sig_x", a_sig_x, 32'd0);
    chk("post_rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("post_rst_rsp_result", a_rsp_result, 32'd0);
    chk("post_rst_rsp_id", 32'(a_rsp_id), 32'd0);
    chk("post_rst_busy", 32'(a_busy), 32'd0);

    // Single request, zero operand.
    step(); a_req_valid = 4'b0001; a_req_x[0] = 32'h0; a_rsp_ready = 1'b1;
    @(negedge clk);
    chk("single_req_ready", 32'(a_req_ready), 32'h1);
    step(); a_req_valid = '0;
    @(negedge clk);
    chk("single_settle_valid", 32'(a_rsp_valid), 32'd0);
    chk("single_settle_busy", 32'(a_busy), 32'd1);
    step();
    @(negedge clk);
    chk("single_rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("single_rsp_result", a_rsp_result, 32'h3F00_0000);
    chk("single_rsp_id", 32'(a_rsp_id), 32'd0);
    step();
    @(negedge clk);
    chk("single_back_idle", 32'(a_busy), 32'd0);

    // All four requesting continuously with rsp_ready high, from a fresh pointer.
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    for (int i = 0; i < N; i++) a_req_x[i] = 32'h4000_0000 + 32'(i);
    a_req_valid = 4'b1111;
    cyc = 0;
    while (ids.size() < 5 && cyc < 40) begin
      @(negedge clk);
      if (a_req_ready != '0) accs.push_back(cyc);
      if (a_rsp_valid && a_rsp_ready) begin
        ids.push_back(int'(a_rsp_id));
        $display("rsp id=%0d result=%h cycle=%0d", a_rsp_id, a_rsp_result, cyc);
      end
      step();
      cyc++;
    end
    chk("stream_count", 32'(ids.size()), 32'd5);
    for (int i = 0; i < ids.size() && i < 5; i++)
      chk($sformatf("stream_id%0d", i), 32'(ids[i]), 32'(exp_ids[i]));
    for (int i = 0; i + 1 < accs.size() && i < 4; i++)
      chk($sformatf("stream_gap%0d", i), 32'(accs[i+1] - accs[i]), 32'd3);
    a_req_valid = 4'b1110;
    wait_rsp(0, 20, ok);
    chk("drop0_rsp_seen", 32'(ok), 32'd1);
    chk("drop0_rsp_id", 32'(a_rsp_id), 32'd1);
    step(); a_req_valid = '0;
    wait_idle(0, 10);

    // Backpressure: response held for 5 cycles while others wait.
    step(); a_rsp_ready = 1'b0; a_req_valid = 4'b0010; a_req_x[1] = 32'hC049_0FDB;
    wait_rsp(0, 10, ok);
    chk("bp_rsp_seen", 32'(ok), 32'd1);
    held_res = a_rsp_result;
    held_id  = a_rsp_id;
    chk("bp_rsp_result", held_res, 32'hFC75_0FDB);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid_stable", 32'(a_rsp_valid), 32'd1);
      chk("bp_result_stable", a_rsp_result, held_res);
      chk("bp_id_stable", 32'(a_rsp_id), 32'(held_id));
      chk("bp_no_ready", 32'(a_req_ready), 32'd0);
      step(); a_req_valid = 4'b1111;
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_handshake_valid", 32'(a_rsp_valid), 32'd1);
    step();
    @(negedge clk);
    chk("bp_idle_busy", 32'(a_busy), 32'd0);
    chk("bp_idle_valid", 32'(a_rsp_valid), 32'd0);
    step(); a_req_valid = '0;
    wait_idle(0, 10);

    // Longer settle time on the second instance.
    step(); b_rsp_ready = 1'b1; b_req_valid = 4'b0001; b_req_x[0] = 32'h3F80_0000;
    @(negedge clk);
    chk("s3_req_ready", 32'(b_req_ready), 32'h1);
    step(); b_req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s3_sig_x", b_sig_x, 32'h3F80_0000);
      chk("s3_no_rsp", 32'(b_rsp_valid), 32'd0);
      step();
    end
    @(negedge clk);
    chk("s3_rsp_valid", 32'(b_rsp_valid), 32'd1);
    chk("s3_rsp_result", b_rsp_result, 32'h03BC_0000);
    chk("s3_rsp_id", 32'(b_rsp_id), 32'd0);
    wait_idle(1, 10);

    // Reset while settling drops the transaction.
    step(); b_req_valid = 4'b0010; b_req_x[1] = 32'h4049_0FDB;
    @(negedge clk);
    chk("rstmid_req_ready", 32'(b_req_ready), 32'h2);
    step(); b_req_valid = '0;
    @(negedge clk);
    chk("rstmid_busy_before", 32'(b_busy), 32'd1);
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", 32'(b_busy), 32'd0);
    chk("rstmid_rsp_valid", 32'(b_rsp_valid), 32'd0);
    chk("rstmid_sig_x", b_sig_x, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      chk("rstmid_no_rsp", 32'(b_rsp_valid), 32'd0);
    end
    step(); b_req_valid = 4'b0100; b_req_x[2] = 32'h3E00_0000;
    wait_rsp(1, 10, ok);
    chk("rstmid_new_seen", 32'(ok), 32'd1);
    chk("rstmid_new_id", 32'(b_rsp_id), 32'd2);
    chk("rstmid_new_result", b_rsp_result, 32'h023C_0000);
    step(); b_req_valid = '0;
    wait_idle(1, 10);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
